dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 256x32 data memory.
- Port A is the CPU load/store path; port B is the loader/debug path.
- Selects one requester, drives the memory read/write strobes for a programmable number of wait cycles, captures read data, and returns a one-cycle ack to the winner.
- Sits between the requesters and the data memory; the memory itself is unchanged.

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter and access sequencer for the single-port 256x32 data
// memory. Port A is the CPU load/store path, port B the loader/debug path.
// A granted transaction holds the memory for WAIT_CYCLES+1 cycles, then the
// winner gets a one-cycle ack (reads also return data in its rdata register).
//
// Build macro DMEM_ARB_RR_EN: when defined, simultaneous requests are served
// round-robin using a last-grant register (first conflict after reset goes
// to A). When undefined, A has fixed priority over B and B can starve.
//
// state | meaning
// IDLE  | no transaction; requests are sampled only here
// BUSY  | memory access, WAIT_CYCLES+1 cycles, strobes driven
// DONE  | one-cycle ack to the winner, strobes low
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wait counter preload; WAIT_CYCLES is limited to 0..15 so four bits suffice.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            stateNext;
  logic [3:0]        cnt;
  logic              cntZero;
  logic              anyReq;
  logic              pickB;
  logic              grantB;
  logic              latWe;
  logic [DATA_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [DATA_W-1:0] aRdataQ;
  logic [DATA_W-1:0] bRdataQ;
  logic              captureRead;
`ifdef DMEM_ARB_RR_EN
  logic              lastGrantB;
`endif

  assign anyReq  = a_req | b_req;
  assign cntZero = (cnt == 4'd0);

  // Winner selection for a transaction starting in IDLE
  always_comb begin
    pickB = 1'b0;
`ifdef DMEM_ARB_RR_EN
    // Lone requester wins; on a conflict the port not granted last time wins.
    // lastGrantB resets to 1, so the first conflict after reset goes to A.
    pickB = b_req & (~a_req | ~lastGrantB);
`else
    pickB = b_req & ~a_req;
`endif
  end

  // Next-state, memory strobe and ack decode
  always_comb begin
    stateNext = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = BUSY;
        end
      end
      BUSY: begin
        mem_read = ~latWe;
        // A single write strobe in the final BUSY cycle commits exactly once.
        mem_write = latWe & cntZero;
        if (cntZero) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        a_ack     = ~grantB;
        b_ack     = grantB;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Transaction latch, wait counter and grant tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 4'd0;
      grantB   <= 1'b0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantB   <= pickB;
            latWe    <= pickB ? b_we    : a_we;
            latAddr  <= pickB ? b_addr  : a_addr;
            latWdata <= pickB ? b_wdata : a_wdata;
            cnt      <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (!cntZero) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last-grant memory for round-robin arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrantB <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      lastGrantB <= pickB;
    end
  end
`endif

  // Read data is taken from the memory in the last BUSY cycle of a read
  assign captureRead = (state == BUSY) & cntZero & ~latWe;

  // Per-port read data registers; only the winner's register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aRdataQ <= '0;
      bRdataQ <= '0;
    end else if (captureRead) begin
      if (grantB) begin
        bRdataQ <= mem_rdata;
      end else begin
        aRdataQ <= mem_rdata;
      end
    end
  end

  // The latch only reloads on a new grant, so the memory bus holds its last
  // values outside BUSY; the strobes alone gate the memory.
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;
  assign a_rdata   = aRdataQ;
  assign b_rdata   = bRdataQ;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses WAIT_CYCLES=0, instance 1 uses 3.
// Each instance has its own memory model. Stimulus pushes expected acks
// (port, both rdata values, ack cycle) into a per-instance queue; a monitor
// pops and compares whenever an ack appears.
module tb_dmem_arbiter;

  typedef struct {
    bit          portB;
    logic [31:0] expA;
    logic [31:0] expB;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rstN;
  logic [1:0]  aReq, aWe, bReq, bWe;
  logic [1:0]  aAck, bAck, memRead, memWrite, busy;
  logic [1:0][31:0] aAddr, aWdata, bAddr, bWdata, memRdata;
  logic [1:0][31:0] aRdata, bRdata, memAddr, memWdata;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  exp_t sbq [2][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busyCnt [2];
  int   readCnt [2];
  int   writeCnt [2];

  always #5 clk = ~clk;

  dmem_arbiter #(.WAIT_CYCLES(0), .DATA_W(32)) u0 (
    .clk(clk), .rst_n(rstN[0]),
    .a_req(aReq[0]), .a_we(aWe[0]), .a_addr(aAddr[0]), .a_wdata(aWdata[0]),
    .a_ack(aAck[0]), .a_rdata(aRdata[0]),
    .b_req(bReq[0]), .b_we(bWe[0]), .b_addr(bAddr[0]), .b_wdata(bWdata[0]),
    .b_ack(bAck[0]), .b_rdata(bRdata[0]),
    .mem_read(memRead[0]), .mem_write(memWrite[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]), .busy(busy[0])
  );

  dmem_arbiter #(.WAIT_CYCLES(3), .DATA_W(32)) u1 (
    .clk(clk), .rst_n(rstN[1]),
    .a_req(aReq[1]), .a_we(aWe[1]), .a_addr(aAddr[1]), .a_wdata(aWdata[1]),
    .a_ack(aAck[1]), .a_rdata(aRdata[1]),
    .b_req(bReq[1]), .b_we(bWe[1]), .b_addr(bAddr[1]), .b_wdata(bWdata[1]),
    .b_ack(bAck[1]), .b_rdata(bRdata[1]),
    .mem_read(memRead[1]), .mem_write(memWrite[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]), .busy(busy[1])
  );

  // Memory models: combinational read, write on the clock edge while strobed
  assign memRdata[0] = mem0[memAddr[0][7:0]];
  assign memRdata[1] = mem1[memAddr[1][7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWrite[0]) mem0[memAddr[0][7:0]] <= memWdata[0];
    if (memWrite[1]) mem1[memAddr[1][7:0]] <= memWdata[1];
  end

  // Strobe/busy cycle counters, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i])     busyCnt[i]  = busyCnt[i] + 1;
      if (memRead[i])  readCnt[i]  = readCnt[i] + 1;
      if (memWrite[i]) writeCnt[i] = writeCnt[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int waitOf(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (aAck[i] || bAck[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("unexpected_ack_i%0d", i), {aAck[i], bAck[i]}, 2'b00);
        end else begin
          e = sbq[i].pop_front();
          chk($sformatf("ack_port_i%0d", i), {aAck[i], bAck[i]}, {~e.portB, e.portB});
          chk($sformatf("ack_cycle_i%0d", i), 64'(cyc), 64'(e.cyc));
          chk($sformatf("a_rdata_i%0d", i), aRdata[i], e.expA);
          chk($sformatf("b_rdata_i%0d", i), bRdata[i], e.expB);
        end
      end
    end
  end

  task automatic pushExp(input int i, input bit pb, input logic [31:0] ea,
                         input logic [31:0] eb, input int c);
    exp_t e;
    e.portB = pb; e.expA = ea; e.expB = eb; e.cyc = c;
    sbq[i].push_back(e);
  endtask

  task automatic setPort(input int i, input bit pb, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (pb) begin
      bReq[i] = req; bWe[i] = we; bAddr[i] = addr; bWdata[i] = wdata;
    end else begin
      aReq[i] = req; aWe[i] = we; aAddr[i] = addr; aWdata[i] = wdata;
    end
  endtask

  // One transaction: issue, corrupt addr/wdata after the grant edge, wait
  // for the ack, drop the request.
  task automatic doTxn(input int i, input bit pb, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] ea, input logic [31:0] eb);
    bit got;
    @(negedge clk);
    pushExp(i, pb, ea, eb, cyc + waitOf(i) + 2);
    setPort(i, pb, 1'b1, we, addr, wdata);
    @(negedge clk);
    setPort(i, pb, 1'b1, we, ~addr, ~wdata);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (aAck[i] || bAck[i]) got = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("ack_seen_i%0d", i), got, 1'b1);
    setPort(i, pb, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chkReset(input int i);
    chk($sformatf("rst_busy_i%0d", i), busy[i], 1'b0);
    chk($sformatf("rst_strobes_i%0d", i), {memRead[i], memWrite[i], aAck[i], bAck[i]}, 4'b0);
    chk($sformatf("rst_rdata_i%0d", i), {aRdata[i], bRdata[i]}, 64'h0);
    chk($sformatf("rst_membus_i%0d", i), {memAddr[i], memWdata[i]}, 64'h0);
  endtask

  initial begin
    int k, s0, s1;
    rstN = 2'b00;
    aReq = '0; aWe = '0; bReq = '0; bWe = '0;
    aAddr = '0; aWdata = '0; bAddr = '0; bWdata = '0;
    for (int i = 0; i < 2; i++) begin
      busyCnt[i] = 0; readCnt[i] = 0; writeCnt[i] = 0;
    end
    for (int j = 0; j < 256; j++) begin
      mem0[j] = 32'h0; mem1[j] = 32'h0;
    end
    mem0[5] = 32'hDEADBEEF;
    mem1[9] = 32'hCAFEF00D;
    mem1[7] = 32'h11111111;

    repeat (2) @(negedge clk);
    chkReset(0);
    chkReset(1);
    rstN = 2'b11;
    repeat (2) @(negedge clk);

    // Single read on A, no wait cycles
    s0 = readCnt[0];
    doTxn(0, 1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 32'h0);
    chk("t1_read_cycles", 64'(readCnt[0] - s0), 64'd1);

    // Write then read back on B; A's rdata must hold
    s0 = writeCnt[0];
    doTxn(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 32'hDEADBEEF, 32'h0);
    chk("t2_write_cycles", 64'(writeCnt[0] - s0), 64'd1);
    chk("t2_mem_word", mem0[16], 32'h12345678);
    doTxn(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h12345678);

    // Both ports held: A,B,A,B with round-robin, A,A,A with fixed priority;
    // A drops after its third ack and B follows.
    @(negedge clk);
    k = cyc;
    pushExp(0, 1'b0, 32'hDEADBEEF, 32'h12345678, k + 2);
`ifdef DMEM_ARB_RR_EN
    pushExp(0, 1'b1, 32'hDEADBEEF, 32'h12345678, k + 5);
`else
    pushExp(0, 1'b0, 32'hDEADBEEF, 32'h12345678, k + 5);
`endif
    pushExp(0, 1'b0, 32'hDEADBEEF, 32'h12345678, k + 8);
    pushExp(0, 1'b1, 32'hDEADBEEF, 32'h12345678, k + 11);
    setPort(0, 1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
    setPort(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (8) @(negedge clk);
    setPort(0, 1'b0, 1'b0, 1'b0, 32'd5, 32'h0);
    repeat (3) @(negedge clk);
    setPort(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (4) @(negedge clk);

    // Read with three wait cycles
    s0 = busyCnt[1];
    s1 = readCnt[1];
    doTxn(1, 1'b0, 1'b0, 32'd9, 32'h0, 32'hCAFEF00D, 32'h0);
    chk("t4_busy_cycles", 64'(busyCnt[1] - s0), 64'd5);
    chk("t4_read_cycles", 64'(readCnt[1] - s1), 64'd4);

    // Write aborted by reset in the second BUSY cycle
    s0 = writeCnt[1];
    @(negedge clk);
    setPort(1, 1'b0, 1'b1, 1'b1, 32'd7, 32'hAA);
    repeat (2) @(negedge clk);
    chk("t5_busy_before_rst", busy[1], 1'b1);
    rstN[1] = 1'b0;
    #1;
    chkReset(1);
    setPort(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rstN[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_write_cycles", 64'(writeCnt[1] - s0), 64'd0);
    chk("t5_mem_word", mem1[7], 32'h11111111);
    chk("t5_idle_after", busy[1], 1'b0);

    chk("sb_drain_i0", 64'(sbq[0].size()), 64'd0);
    chk("sb_drain_i1", 64'(sbq[1].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
